// File: rtl/demux_route_if.sv
// Stream bundle for demux_route: one select-tagged input stream, two routed
// output streams and the per-port routed-word counters.
interface demux_route_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             Sel;
  logic [WIDTH-1:0] Din;
  logic             A_valid;
  logic             A_ready;
  logic [WIDTH-1:0] A_data;
  logic             B_valid;
  logic             B_ready;
  logic [WIDTH-1:0] B_data;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  // Producer/consumer side: drives the input stream and both output readies.
  modport master (
    output in_valid, Sel, Din, A_ready, B_ready,
    input  in_ready, A_valid, A_data, B_valid, B_data, cnt_a, cnt_b
  );

  // Router side.
  modport slave (
    input  in_valid, Sel, Din, A_ready, B_ready,
    output in_ready, A_valid, A_data, B_valid, B_data, cnt_a, cnt_b
  );
endinterface

// File: rtl/demux_route.sv
// Registered 1-to-2 router: each accepted word lands in the FIFO picked by Sel,
// with a saturating routed-word counter per destination.
module demux_route #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  demux_route_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [1:0]             full;
  logic [1:0]             valid;
  logic [1:0]             out_ready;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0][WIDTH-1:0]  head;
  logic [1:0][CNT_W-1:0]  cnt;
  logic                   accept;

  assign out_ready = {bus.B_ready, bus.A_ready};

  // Readiness looks only at the selected FIFO's registered fill level, so a
  // pop in the same cycle never frees a slot for the incoming word.
  assign bus.in_ready = bus.Sel ? !full[1] : !full[0];
  assign accept       = bus.in_valid & bus.in_ready & !clr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [WIDTH-1:0] mem_reg [DEPTH];
      logic [AW-1:0]    wr_ptr_reg;
      logic [AW-1:0]    rd_ptr_reg;
      logic [AW:0]      occ_reg;
      logic [CNT_W-1:0] cnt_reg;

      assign push[gi]  = accept & (bus.Sel == 1'(gi));
      assign pop[gi]   = valid[gi] & out_ready[gi] & !clr;
      assign full[gi]  = (occ_reg == FULL_LVL);
      assign valid[gi] = (occ_reg != '0);
      assign head[gi]  = valid[gi] ? mem_reg[rd_ptr_reg] : '0;
      assign cnt[gi]   = cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          occ_reg    <= '0;
          cnt_reg    <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
          end
        end else if (clr) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          occ_reg    <= '0;
          cnt_reg    <= '0;
        end else begin
          if (push[gi]) begin
            mem_reg[wr_ptr_reg] <= bus.Din;
            wr_ptr_reg          <= wr_ptr_reg + 1'b1;
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          case ({push[gi], pop[gi]})
            2'b10:   occ_reg <= occ_reg + 1'b1;
            2'b01:   occ_reg <= occ_reg - 1'b1;
            default: occ_reg <= occ_reg;
          endcase
          if (push[gi] && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign bus.A_valid = valid[0];
  assign bus.A_data  = head[0];
  assign bus.B_valid = valid[1];
  assign bus.B_data  = head[1];
  assign bus.cnt_a   = cnt[0];
  assign bus.cnt_b   = cnt[1];
endmodule

// File: tb/tb_demux_route.sv
// Directed bench for demux_route: stimulus queues expected words per port, an
// independent monitor pops and compares them on every output handshake.
module tb_demux_route;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [WIDTH-1:0] exp_a [$];
  logic [WIDTH-1:0] exp_b [$];

  demux_route_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux_route #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, act, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: every completed output handshake must match the next queued word.
  always @(negedge clk) begin
    if (rst_n && !clr) begin
      if (bus.A_valid && bus.A_ready) begin
        if (exp_a.size() == 0) chk("a_unexpected_pop", bus.A_data, 32'hFFFF_FFFF);
        else chk("a_data", bus.A_data, exp_a.pop_front());
      end
      if (bus.B_valid && bus.B_ready) begin
        if (exp_b.size() == 0) chk("b_unexpected_pop", bus.B_data, 32'hFFFF_FFFF);
        else chk("b_data", bus.B_data, exp_b.pop_front());
      end
      if (!bus.A_valid) chk("a_data_zero", bus.A_data, 32'h0);
      if (!bus.B_valid) chk("b_data_zero", bus.B_data, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.Sel      = 1'b0;
    bus.Din      = '0;
    bus.A_ready  = 1'b0;
    bus.B_ready  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    at_neg();
    chk("rst_a_valid", bus.A_valid, 0);
    chk("rst_b_valid", bus.B_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cnt_a", bus.cnt_a, 0);
    chk("rst_cnt_b", bus.cnt_b, 0);
    step();
    rst_n = 1'b1;

    // Basic routing
    bus.A_ready = 1'b1;
    bus.B_ready = 1'b1;
    bus.in_valid = 1'b1; bus.Sel = 1'b0; bus.Din = 32'h1111_1111;
    exp_a.push_back(32'h1111_1111);
    at_neg(); chk("basic_in_ready_a", bus.in_ready, 1);
    step();
    bus.Sel = 1'b1; bus.Din = 32'h2222_2222;
    exp_b.push_back(32'h2222_2222);
    at_neg(); chk("basic_a_valid_lat1", bus.A_valid, 1);
    chk("basic_cnt_a", bus.cnt_a, 1);
    step();
    bus.in_valid = 1'b0;
    at_neg(); chk("basic_b_valid_lat1", bus.B_valid, 1);
    chk("basic_a_drained", bus.A_valid, 0);
    chk("basic_cnt_b", bus.cnt_b, 1);
    step();

    // Backpressure and full
    bus.A_ready = 1'b0;
    bus.in_valid = 1'b1; bus.Sel = 1'b0; bus.Din = 32'hA0;
    exp_a.push_back(32'hA0);
    at_neg(); chk("bp_accept_a0", bus.in_ready, 1);
    step();
    bus.Din = 32'hA1;
    exp_a.push_back(32'hA1);
    at_neg(); chk("bp_accept_a1", bus.in_ready, 1);
    step();
    bus.Din = 32'hA2;
    at_neg(); chk("bp_full_refuse", bus.in_ready, 0);
    step();
    bus.in_valid = 1'b0; bus.Sel = 1'b1;
    at_neg(); chk("bp_b_side_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b1; bus.Sel = 1'b0; bus.A_ready = 1'b1;
    at_neg(); chk("bp_full_during_pop", bus.in_ready, 0);
    step();
    exp_a.push_back(32'hA2);
    at_neg(); chk("bp_ready_after_pop", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    at_neg(); chk("bp_cnt_a", bus.cnt_a, 4);
    step();
    at_neg(); chk("bp_a_empty", bus.A_valid, 0);
    step();

    // Simultaneous push/pop across pointer wrap
    bus.in_valid = 1'b1; bus.Sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.Din = 32'(i);
      exp_a.push_back(32'(i));
      at_neg();
      chk("wrap_in_ready", bus.in_ready, 1);
      chk("wrap_a_valid", bus.A_valid, (i > 0) ? 1 : 0);
      step();
    end
    bus.in_valid = 1'b0;
    at_neg();
    step();
    at_neg(); chk("wrap_cnt_a", bus.cnt_a, 12);
    chk("wrap_a_left", exp_a.size(), 0);
    step();

    // Saturation on B after a flush
    clr = 1'b1;
    step();
    clr = 1'b0;
    at_neg(); chk("clr_cnt_a", bus.cnt_a, 0);
    chk("clr_cnt_b", bus.cnt_b, 0);
    step();
    bus.in_valid = 1'b1; bus.Sel = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.Din = 32'hB000_0000 + 32'(i);
      exp_b.push_back(32'hB000_0000 + 32'(i));
      at_neg();
      chk("sat_cnt_b", bus.cnt_b, (i > 15) ? 15 : i);
      step();
    end
    bus.in_valid = 1'b0;
    at_neg(); chk("sat_cnt_b_hold", bus.cnt_b, 15);
    chk("sat_cnt_a", bus.cnt_a, 0);
    step();
    at_neg(); chk("sat_b_left", exp_b.size(), 0);
    step();

    // clr with concurrent push and pop requests
    bus.A_ready = 1'b0;
    bus.in_valid = 1'b1; bus.Sel = 1'b0;
    bus.Din = 32'hC0; exp_a.push_back(32'hC0);
    step();
    bus.Din = 32'hC1; exp_a.push_back(32'hC1);
    step();
    clr = 1'b1; bus.A_ready = 1'b1; bus.Din = 32'hC2;
    at_neg(); chk("clr_in_ready_preclear", bus.in_ready, 0);
    chk("clr_a_valid_pre", bus.A_valid, 1);
    step();
    exp_a.delete();
    clr = 1'b0; bus.in_valid = 1'b0;
    at_neg(); chk("clr_a_valid", bus.A_valid, 0);
    chk("clr_cnt_a_after", bus.cnt_a, 0);
    chk("clr_cnt_b_after", bus.cnt_b, 0);
    chk("clr_in_ready", bus.in_ready, 1);
    step();

    // Refill, then asynchronous reset mid-cycle
    bus.A_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.Din = 32'hD0; exp_a.push_back(32'hD0);
    step();
    bus.Din = 32'hD1; exp_a.push_back(32'hD1);
    step();
    bus.in_valid = 1'b0;
    at_neg(); chk("refill_a_valid", bus.A_valid, 1);
    chk("refill_cnt_a", bus.cnt_a, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_a_valid", bus.A_valid, 0);
    chk("arst_a_data", bus.A_data, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_cnt_a", bus.cnt_a, 0);
    exp_a.delete();
    step();
    rst_n = 1'b1;
    at_neg(); chk("post_rst_a_valid", bus.A_valid, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/demux_route.md
# demux_route

Registered 1-to-2 result router for the 32-bit RISC-V datapath, the distribution counterpart of the 2:1 operand-select muxes. A single input stream carries a word and a select bit. Each accepted word is steered into one of two per-destination FIFOs: port A when select is 0, port B when select is 1. Both sides use valid/ready handshakes, and per-port saturating counters record how many words were routed, so that writeback consumers can stall independently.

## Interface
- WIDTH, 32, data width of every word.
- DEPTH, 2, entries per destination FIFO; must be a power of two and ≥ 2.
- CNT_W, 16, width of each routed-word counter.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low. Everything in the block sits on the single clock clk.
- clr  input  1  synchronous flush of both FIFOs and both counters.
- in_valid  input  1  input word present.
- in_ready  output  1  input word can be accepted this cycle.
- Sel  input  1  destination select: 0 means port A, 1 means port B. Qualified by in_valid.
- Din  input  WIDTH  input word.
- A_valid  output  1  port A head entry valid.
- A_ready  input  1  port A consumer takes the head.
- A_data  output  WIDTH  port A head word.
- B_valid, B_ready, B_data  identical set for port B.
- cnt_a  output  CNT_W  words accepted toward port A, saturating.
- cnt_b  output  CNT_W  words accepted toward port B, saturating.

## Operation
- Each port has its own FIFO of DEPTH entries, with a write pointer, a read pointer and an occupancy count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- in_ready = !full(Sel ? B : A). It is combinational on Sel and the registered occupancy only, with no pass-through from the output ready signals.
- A push happens when in_valid & in_ready. The word goes into the selected FIFO only; the other FIFO is untouched.
- X_valid = (occupancy of X != 0). X_data = the head entry when X_valid is 1, and is forced to 0 when X_valid is 0.
- A pop happens when X_valid & X_ready. It advances the read pointer.
- A push and a pop on the same FIFO in the same cycle leave occupancy unchanged and update both pointers.
- A full FIFO refuses a push even if it is popped in the same cycle, because in_ready depends only on full.
- A push to one port and a pop from the other port in the same cycle are independent.
- Order is first-in first-out within each port. Ordering between ports is not preserved.
- Counters:
  - cnt_a increments by 1 on every push to A, and cnt_b on every push to B.
  - Each counter holds at 2^CNT_W−1 and does not wrap.
- clr has priority over push and pop. When clr is 1, both occupancies, all pointers and both counters go to 0 at the next edge, and no push or pop takes effect that cycle. in_ready still reflects the pre-clear state during the clr cycle; it is not used to accept.
- Ready/valid rules:
  - The consumer may assert X_ready with X_valid low; this has no effect.
  - Once X_valid is high it stays high until popped or cleared.

## Timing
- Reset (rst_n low, asynchronous) sets all of the following, and they hold until the first edge after rst_n deasserts:
  - occupancies = 0, pointers = 0, cnt_a = cnt_b = 0, storage = 0.
  - A_valid = B_valid = 0, A_data = B_data = 0, in_ready = 1.
- Reset asserted mid-operation discards all buffered words immediately. No handshake completes in the reset cycle.
- Latency: a word pushed at edge N shows on X_valid/X_data after edge N, i.e. it can be popped in cycle N+1. One cycle minimum, no combinational Din→X_data path.
- Throughput: one push per cycle sustained into a port whose consumer holds ready high, provided DEPTH ≥ 2.
- Counter update is visible the cycle after the push edge.
- A full → not-full transition raises in_ready one cycle after the pop edge.

## Test plan
- **Reset values.** Hold rst_n=0 for 3 cycles, then release. Required: A_valid=B_valid=0, A_data=B_data=0, in_ready=1, cnt_a=cnt_b=0.
- **Basic routing.** Push 0x11111111 with Sel=0, then 0x22222222 with Sel=1, both ready=1. Required: A delivers 0x11111111 one cycle after its push, B delivers 0x22222222 one cycle after its push, cnt_a=1, cnt_b=1.
- **Backpressure and full.** A_ready=0; push 0xA0, 0xA1, 0xA2 with Sel=0. Required: 0xA0 and 0xA1 accepted, in_ready=0 on the third. Sel=1 still gives in_ready=1. Raise A_ready: A delivers 0xA0 then 0xA1, and 0xA2 is accepted the cycle after the first pop.
- **Simultaneous push/pop at wrap.** DEPTH=2, A_ready=1, stream 8 words 0..7 to A back-to-back. Required: outputs 0..7 in order, occupancy never exceeds 1, pointers wrap with no loss.
- **Saturation.** With CNT_W=4, push 17 words to B. Required: cnt_b=15 and held there, cnt_a=0.
- **clr and mid-op reset.** Fill A with 2 words, assert clr together with in_valid and A_ready. Required: next cycle A_valid=0, cnt_a=0, no word accepted or popped. Refill, then pulse rst_n low mid-cycle. Required: A_valid falls immediately.
